// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename tags (tag MSB = busy).
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle committing value to the read ports.
module reg_file #(
    parameter int REG_NUM   = 32,
    parameter int DATA_W    = 32,
    parameter int ROB_POS_W = 4,
    parameter int REG_AW    = $clog2(REG_NUM),
    parameter int TAG_W     = ROB_POS_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clr,
    input  logic              issue_enable,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [TAG_W-1:0]  issue_rob_pos,
    input  logic              commit_enable,
    input  logic [REG_AW-1:0] commit_rd,
    input  logic [DATA_W-1:0] commit_val,
    input  logic [TAG_W-1:0]  commit_rob_pos,
    input  logic [REG_AW-1:0] dc_rs1,
    input  logic [REG_AW-1:0] dc_rs2,
    output logic [DATA_W-1:0] rs1_val,
    output logic [DATA_W-1:0] rs2_val,
    output logic [TAG_W-1:0]  rs1_dep,
    output logic [TAG_W-1:0]  rs2_dep,
    output logic [5:0]        busy_cnt
);

    logic [REG_NUM-1:0][DATA_W-1:0] val_reg;
    logic [REG_NUM-1:0][DATA_W-1:0] val_next;
    logic [REG_NUM-1:0][TAG_W-1:0]  tag_reg;
    logic [REG_NUM-1:0][TAG_W-1:0]  tag_next;
    logic [5:0]                     busy_cnt_reg;
    logic [5:0]                     busy_cnt_next;

    logic commit_go;
    logic issue_go;

    assign commit_go = rdy && commit_enable && (commit_rd != '0);
    assign issue_go  = rdy && issue_enable && (issue_rd != '0) && !clr;

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                assign val_next[gi] = '0;
                assign tag_next[gi] = '0;
            end else begin : g_rn
                logic commit_hit;
                logic issue_hit;
                assign commit_hit = commit_go && (commit_rd == REG_AW'(gi));
                assign issue_hit  = issue_go && (issue_rd == REG_AW'(gi));

                assign val_next[gi] = commit_hit ? commit_val : val_reg[gi];

                // Issue beats a same-cycle commit; commit only clears its own tag.
                always_comb begin
                    tag_next[gi] = tag_reg[gi];
                    if (rdy && clr) begin
                        tag_next[gi] = '0;
                    end else if (issue_hit) begin
                        tag_next[gi] = issue_rob_pos;
                    end else if (commit_hit && (tag_reg[gi] == commit_rob_pos)) begin
                        tag_next[gi] = '0;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy_cnt_next = busy_cnt_next + 6'(|tag_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_reg      <= '0;
            tag_reg      <= '0;
            busy_cnt_reg <= '0;
        end else if (rdy) begin
            val_reg      <= val_next;
            tag_reg      <= tag_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

`ifdef REGFILE_BYPASS_EN
    logic byp1;
    logic byp2;
    assign byp1 = commit_go && (dc_rs1 == commit_rd) && (tag_reg[dc_rs1] == commit_rob_pos);
    assign byp2 = commit_go && (dc_rs2 == commit_rd) && (tag_reg[dc_rs2] == commit_rob_pos);

    assign rs1_val = byp1 ? commit_val : val_reg[dc_rs1];
    assign rs2_val = byp2 ? commit_val : val_reg[dc_rs2];
    assign rs1_dep = byp1 ? '0 : tag_reg[dc_rs1];
    assign rs2_dep = byp2 ? '0 : tag_reg[dc_rs2];
`else
    assign rs1_val = val_reg[dc_rs1];
    assign rs2_val = val_reg[dc_rs2];
    assign rs1_dep = tag_reg[dc_rs1];
    assign rs2_dep = tag_reg[dc_rs2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: rename, commit, flush, freeze, x0 and reset.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        clr;
    logic        issue_enable;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rob_pos;
    logic        commit_enable;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [4:0]  commit_rob_pos;
    logic [4:0]  dc_rs1;
    logic [4:0]  dc_rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1_dep;
    logic [4:0]  rs2_dep;
    logic [5:0]  busy_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    reg_file dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .clr            (clr),
        .issue_enable   (issue_enable),
        .issue_rd       (issue_rd),
        .issue_rob_pos  (issue_rob_pos),
        .commit_enable  (commit_enable),
        .commit_rd      (commit_rd),
        .commit_val     (commit_val),
        .commit_rob_pos (commit_rob_pos),
        .dc_rs1         (dc_rs1),
        .dc_rs2         (dc_rs2),
        .rs1_val        (rs1_val),
        .rs2_val        (rs2_val),
        .rs1_dep        (rs1_dep),
        .rs2_dep        (rs2_dep),
        .busy_cnt       (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the currently driven controls, then controls are dropped.
    task automatic tick();
        $display("txn t=%0t rdy=%0b clr=%0b iss=%0b rd=%0d tag=%h com=%0b rd=%0d tag=%h val=%h",
                 $time, rdy, clr, issue_enable, issue_rd, issue_rob_pos,
                 commit_enable, commit_rd, commit_rob_pos, commit_val);
        @(posedge clk);
        #1;
        issue_enable  = 1'b0;
        commit_enable = 1'b0;
        clr           = 1'b0;
        rdy           = 1'b1;
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [4:0] tag);
        issue_enable = 1'b1; issue_rd = rd; issue_rob_pos = tag;
        tick();
    endtask

    task automatic test_reset();
        dc_rs1 = 5'd5; dc_rs2 = 5'd31;
        #2;
        vec_cnt++; if (rs1_val !== 32'h0) begin err_cnt++; $display("FAIL reset_val got %h exp %h", rs1_val, 32'h0); end
        vec_cnt++; if (rs2_dep !== 5'h0) begin err_cnt++; $display("FAIL reset_dep got %h exp %h", rs2_dep, 5'h0); end
        vec_cnt++; if (busy_cnt !== 6'd0) begin err_cnt++; $display("FAIL reset_busy got %0d exp %0d", busy_cnt, 0); end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_commit_clears();
        do_issue(5'd5, 5'h13);
        dc_rs1 = 5'd5;
        vec_cnt++; if (rs1_dep !== 5'h13) begin err_cnt++; $display("FAIL issue_dep got %h exp %h", rs1_dep, 5'h13); end
        vec_cnt++; if (busy_cnt !== 6'd1) begin err_cnt++; $display("FAIL issue_busy got %0d exp %0d", busy_cnt, 1); end
        commit_enable = 1'b1; commit_rd = 5'd5; commit_rob_pos = 5'h13; commit_val = 32'hDEAD;
        tick();
        vec_cnt++; if (rs1_val !== 32'hDEAD) begin err_cnt++; $display("FAIL commit_val got %h exp %h", rs1_val, 32'hDEAD); end
        vec_cnt++; if (rs1_dep !== 5'h0) begin err_cnt++; $display("FAIL commit_dep got %h exp %h", rs1_dep, 5'h0); end
        vec_cnt++; if (busy_cnt !== 6'd0) begin err_cnt++; $display("FAIL commit_busy got %0d exp %0d", busy_cnt, 0); end
    endtask

    task automatic test_younger_writer();
        do_issue(5'd7, 5'h11);
        do_issue(5'd7, 5'h12);
        commit_enable = 1'b1; commit_rd = 5'd7; commit_rob_pos = 5'h11; commit_val = 32'h1;
        tick();
        dc_rs1 = 5'd7;
        #1;
        vec_cnt++; if (rs1_val !== 32'h1) begin err_cnt++; $display("FAIL younger_val got %h exp %h", rs1_val, 32'h1); end
        vec_cnt++; if (rs1_dep !== 5'h12) begin err_cnt++; $display("FAIL younger_dep got %h exp %h", rs1_dep, 5'h12); end
        vec_cnt++; if (busy_cnt !== 6'd1) begin err_cnt++; $display("FAIL younger_busy got %0d exp %0d", busy_cnt, 1); end
    endtask

    task automatic test_same_cycle();
        do_issue(5'd3, 5'h10);
        commit_enable = 1'b1; commit_rd = 5'd3; commit_rob_pos = 5'h10; commit_val = 32'h33;
        issue_enable = 1'b1; issue_rd = 5'd3; issue_rob_pos = 5'h14;
        tick();
        dc_rs2 = 5'd3;
        #1;
        vec_cnt++; if (rs2_val !== 32'h33) begin err_cnt++; $display("FAIL same_val got %h exp %h", rs2_val, 32'h33); end
        vec_cnt++; if (rs2_dep !== 5'h14) begin err_cnt++; $display("FAIL same_dep got %h exp %h", rs2_dep, 5'h14); end
        vec_cnt++; if (busy_cnt !== 6'd2) begin err_cnt++; $display("FAIL same_busy got %0d exp %0d", busy_cnt, 2); end
    endtask

    task automatic test_bypass();
        do_issue(5'd9, 5'h15);
        dc_rs2 = 5'd9;
        commit_enable = 1'b1; commit_rd = 5'd9; commit_rob_pos = 5'h15; commit_val = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        vec_cnt++; if (rs2_val !== 32'h77) begin err_cnt++; $display("FAIL bypass_val got %h exp %h", rs2_val, 32'h77); end
        vec_cnt++; if (rs2_dep !== 5'h0) begin err_cnt++; $display("FAIL bypass_dep got %h exp %h", rs2_dep, 5'h0); end
`else
        vec_cnt++; if (rs2_val !== 32'h0) begin err_cnt++; $display("FAIL nobypass_val got %h exp %h", rs2_val, 32'h0); end
        vec_cnt++; if (rs2_dep !== 5'h15) begin err_cnt++; $display("FAIL nobypass_dep got %h exp %h", rs2_dep, 5'h15); end
`endif
        tick();
        vec_cnt++; if (rs2_val !== 32'h77) begin err_cnt++; $display("FAIL bypass_after_val got %h exp %h", rs2_val, 32'h77); end
        vec_cnt++; if (rs2_dep !== 5'h0) begin err_cnt++; $display("FAIL bypass_after_dep got %h exp %h", rs2_dep, 5'h0); end
        vec_cnt++; if (busy_cnt !== 6'd2) begin err_cnt++; $display("FAIL bypass_busy got %0d exp %0d", busy_cnt, 2); end
    endtask

    task automatic test_rdy_low();
        rdy = 1'b0; clr = 1'b1;
        issue_enable = 1'b1; issue_rd = 5'd10; issue_rob_pos = 5'h16;
        commit_enable = 1'b1; commit_rd = 5'd7; commit_rob_pos = 5'h12; commit_val = 32'h99;
        dc_rs1 = 5'd7; dc_rs2 = 5'd10;
        #1;
        vec_cnt++; if (rs1_dep !== 5'h12) begin err_cnt++; $display("FAIL frozen_live_dep got %h exp %h", rs1_dep, 5'h12); end
        tick();
        vec_cnt++; if (rs1_val !== 32'h1) begin err_cnt++; $display("FAIL frozen_val got %h exp %h", rs1_val, 32'h1); end
        vec_cnt++; if (rs1_dep !== 5'h12) begin err_cnt++; $display("FAIL frozen_dep got %h exp %h", rs1_dep, 5'h12); end
        vec_cnt++; if (rs2_dep !== 5'h0) begin err_cnt++; $display("FAIL frozen_issue got %h exp %h", rs2_dep, 5'h0); end
        vec_cnt++; if (busy_cnt !== 6'd2) begin err_cnt++; $display("FAIL frozen_busy got %0d exp %0d", busy_cnt, 2); end
    endtask

    task automatic test_clr();
        do_issue(5'd2, 5'h17);
        do_issue(5'd4, 5'h18);
        vec_cnt++; if (busy_cnt !== 6'd4) begin err_cnt++; $display("FAIL preclr_busy got %0d exp %0d", busy_cnt, 4); end
        clr = 1'b1;
        commit_enable = 1'b1; commit_rd = 5'd1; commit_rob_pos = 5'h19; commit_val = 32'h40;
        issue_enable = 1'b1; issue_rd = 5'd6; issue_rob_pos = 5'h1A;
        tick();
        dc_rs1 = 5'd1; dc_rs2 = 5'd2;
        #1;
        vec_cnt++; if (rs1_val !== 32'h40) begin err_cnt++; $display("FAIL clr_commit_val got %h exp %h", rs1_val, 32'h40); end
        vec_cnt++; if (rs2_dep !== 5'h0) begin err_cnt++; $display("FAIL clr_dep2 got %h exp %h", rs2_dep, 5'h0); end
        dc_rs1 = 5'd4; dc_rs2 = 5'd6;
        #1;
        vec_cnt++; if (rs1_dep !== 5'h0) begin err_cnt++; $display("FAIL clr_dep4 got %h exp %h", rs1_dep, 5'h0); end
        vec_cnt++; if (rs2_dep !== 5'h0) begin err_cnt++; $display("FAIL clr_issue_dep got %h exp %h", rs2_dep, 5'h0); end
        vec_cnt++; if (busy_cnt !== 6'd0) begin err_cnt++; $display("FAIL clr_busy got %0d exp %0d", busy_cnt, 0); end
    endtask

    task automatic test_x0();
        issue_enable = 1'b1; issue_rd = 5'd0; issue_rob_pos = 5'h1B;
        commit_enable = 1'b1; commit_rd = 5'd0; commit_rob_pos = 5'h1B; commit_val = 32'h55;
        dc_rs1 = 5'd0;
        #1;
        vec_cnt++; if (rs1_val !== 32'h0) begin err_cnt++; $display("FAIL x0_live_val got %h exp %h", rs1_val, 32'h0); end
        tick();
        vec_cnt++; if (rs1_val !== 32'h0) begin err_cnt++; $display("FAIL x0_val got %h exp %h", rs1_val, 32'h0); end
        vec_cnt++; if (rs1_dep !== 5'h0) begin err_cnt++; $display("FAIL x0_dep got %h exp %h", rs1_dep, 5'h0); end
        vec_cnt++; if (busy_cnt !== 6'd0) begin err_cnt++; $display("FAIL x0_busy got %0d exp %0d", busy_cnt, 0); end
    endtask

    task automatic test_reset_mid();
        do_issue(5'd12, 5'h1C);
        dc_rs1 = 5'd12; dc_rs2 = 5'd1;
        #1;
        vec_cnt++; if (rs1_dep !== 5'h1C) begin err_cnt++; $display("FAIL prerst_dep got %h exp %h", rs1_dep, 5'h1C); end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (rs1_dep !== 5'h0) begin err_cnt++; $display("FAIL rst_mid_dep got %h exp %h", rs1_dep, 5'h0); end
        vec_cnt++; if (rs2_val !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_val got %h exp %h", rs2_val, 32'h0); end
        vec_cnt++; if (busy_cnt !== 6'd0) begin err_cnt++; $display("FAIL rst_mid_busy got %0d exp %0d", busy_cnt, 0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; clr = 1'b0;
        issue_enable = 1'b0; issue_rd = '0; issue_rob_pos = '0;
        commit_enable = 1'b0; commit_rd = '0; commit_val = '0; commit_rob_pos = '0;
        dc_rs1 = '0; dc_rs2 = '0;
        test_reset();
        test_commit_clears();
        test_younger_writer();
        test_same_cycle();
        test_bypass();
        test_rdy_low();
        test_clr();
        test_x0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
